// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the fetch-stage program counter.
package pc_fetch_pkg;

    typedef enum logic [2:0] {
        SEL_RESET,
        SEL_REDIRECT,
        SEL_HOLD,
        SEL_RAS,
        SEL_SEQ
    } next_pc_sel_e;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC0_0000;
    localparam int unsigned PC_INCR              = 4;

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack with a top pointer and saturating count;
// on overflow the oldest entry is overwritten.
module return_addr_stack
    import pc_fetch_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_c,
    output logic             empty,
    output logic             full
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    logic [WIDTH-1:0] mem [RAS_DEPTH];
    logic [PTR_W-1:0] top_ptr;
    logic [PTR_W-1:0] top_ptr_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             wr_en;
    logic [PTR_W-1:0] wr_idx;
    logic             is_empty;

    assign is_empty = (count == CNT_W'(0));
    assign top_c    = mem[top_ptr];

    // Pointer/count update; a pop on an empty stack degrades to push-only or no-op.
    always_comb begin
        top_ptr_next = top_ptr;
        count_next   = count;
        wr_en        = 1'b0;
        wr_idx       = top_ptr;
        if (push && pop && !is_empty) begin
            wr_en = 1'b1;
        end else if (push) begin
            wr_en        = 1'b1;
            wr_idx       = top_ptr + PTR_W'(1);
            top_ptr_next = top_ptr + PTR_W'(1);
            if (count != CNT_W'(RAS_DEPTH)) begin
                count_next = count + CNT_W'(1);
            end
        end else if (pop && !is_empty) begin
            top_ptr_next = top_ptr - PTR_W'(1);
            count_next   = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            top_ptr <= '0;
            count   <= '0;
            empty   <= 1'b1;
            full    <= 1'b0;
        end else begin
            top_ptr <= top_ptr_next;
            count   <= count_next;
            empty   <= (count_next == CNT_W'(0));
            full    <= (count_next == CNT_W'(RAS_DEPTH));
        end
    end

    // Entry contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch-stage PC register with stall, execute redirect and RAS-predicted returns.
module pc_fetch_unit
    import pc_fetch_pkg::*;
#(
    parameter int unsigned       WIDTH        = 32,
    parameter logic [WIDTH-1:0]  RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
    parameter int unsigned       RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
    input  logic             push_valid,
    input  logic [WIDTH-1:0] push_addr,
    input  logic             pop_valid,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             misaligned
);

    next_pc_sel_e     sel;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] ras_top;
    logic             ras_push;
    logic             ras_pop;

    // Decode hints are stale when the slot is held or squashed.
    assign ras_push = push_valid && !stall && !redirect_valid;
    assign ras_pop  = pop_valid  && !stall && !redirect_valid;

    return_addr_stack #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (push_addr),
        .top_c     (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    always_comb begin
        sel = SEL_SEQ;
        if (rst) begin
            sel = SEL_RESET;
        end else if (redirect_valid) begin
            sel = SEL_REDIRECT;
        end else if (stall) begin
            sel = SEL_HOLD;
        end else if (ras_pop && !ras_empty) begin
            sel = SEL_RAS;
        end
    end

    always_comb begin
        pc_next = pc_plus4;
        case (sel)
            SEL_RESET:    pc_next = RESET_VECTOR;
            SEL_REDIRECT: pc_next = redirect_target;
            SEL_HOLD:     pc_next = pc;
            SEL_RAS:      pc_next = ras_top;
            default:      pc_next = pc_plus4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_VECTOR;
            pc_plus4   <= RESET_VECTOR + WIDTH'(PC_INCR);
            misaligned <= 1'b0;
        end else begin
            pc         <= pc_next;
            pc_plus4   <= pc_next + WIDTH'(PC_INCR);
            misaligned <= |pc_next[1:0];
        end
    end

endmodule
